// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU.
// It returns {remainder, quotient} together with a registered ready flag.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BYZERO = 2'd1;
  localparam logic [1:0] ON     = 2'd2;
  localparam logic [1:0] END    = 2'd3;

  logic [1:0]  state_reg;
  logic [5:0]  cnt_reg;
  logic [64:0] work_reg;
  logic [31:0] divisor_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic [63:0] result_reg;
  logic        ready_reg;

  logic        sign1;
  logic        sign2;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [64:0] shifted;
  logic [33:0] trial;
  logic [64:0] step;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // Magnitudes of the operands; 0x80000000 stays 0x80000000 and is read as unsigned.
  assign sign1 = signed_div_i & opdata1_i[31];
  assign sign2 = signed_div_i & opdata2_i[31];
  assign abs1  = sign1 ? (~opdata1_i + 32'd1) : opdata1_i;
  assign abs2  = sign2 ? (~opdata2_i + 32'd1) : opdata2_i;

  // One restoring step. A borrow out of the 34-bit trial means the subtraction failed.
  assign shifted = {work_reg[63:0], 1'b0};
  assign trial   = {1'b0, shifted[64:32]} - {2'b00, divisor_reg};
  assign step    = trial[33] ? shifted : {trial[32:0], shifted[31:1], 1'b1};

  assign quot     = step[31:0];
  assign rem      = step[63:32];
  assign quot_fix = neg_q_reg ? (~quot + 32'd1) : quot;
  assign rem_fix  = neg_r_reg ? (~rem + 32'd1) : rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= FREE;
      cnt_reg     <= 6'd0;
      work_reg    <= 65'd0;
      divisor_reg <= 32'd0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      result_reg  <= 64'd0;
      ready_reg   <= 1'b0;
    end else begin
      case (state_reg)
        FREE: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state_reg <= BYZERO;
            end else begin
              state_reg   <= ON;
              cnt_reg     <= 6'd0;
              work_reg    <= {33'd0, abs1};
              divisor_reg <= abs2;
              neg_q_reg   <= sign1 ^ sign2;
              neg_r_reg   <= sign1;
            end
          end
        end
        BYZERO: begin
          state_reg  <= END;
          result_reg <= 64'd0;
          ready_reg  <= 1'b1;
        end
        ON: begin
          if (annul_i) begin
            state_reg <= FREE;
            cnt_reg   <= 6'd0;
          end else begin
            work_reg <= step;
            cnt_reg  <= cnt_reg + 6'd1;
            // The last step's result goes straight into the output register.
            if (cnt_reg == 6'd31) begin
              state_reg  <= END;
              result_reg <= {rem_fix, quot_fix};
              ready_reg  <= 1'b1;
            end
          end
        end
        END: begin
          if (!start_i) begin
            state_reg  <= FREE;
            cnt_reg    <= 6'd0;
            result_reg <= 64'd0;
            ready_reg  <= 1'b0;
          end
        end
        default: state_reg <= FREE;
      endcase
    end
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for div.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%016h expected=0x%016h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request and hold start until ready. Edges are counted with the
  // accepting edge as edge 1.
  task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_edges);
    int n;
    logic [63:0] held;
    signed_div_i = sd;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      // Operands that change while the divider is busy must be ignored.
      opdata1_i = 32'h1234_5678;
      opdata2_i = 32'h0000_0000;
      signed_div_i = ~sd;
    end while (!ready_o && n < 100);
    check_eq({tag, "_latency"}, 64'(n), 64'(exp_edges));
    check_eq({tag, "_result"}, result_o, exp);
    held = result_o;
    tick();
    tick();
    check_eq({tag, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
    check_eq({tag, "_hold_result"}, result_o, held);
    start_i = 1'b0;
    tick();
    check_eq({tag, "_clr_ready"}, {63'd0, ready_o}, 64'd0);
    check_eq({tag, "_clr_result"}, result_o, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();
    tick();
    check_eq("reset_ready", {63'd0, ready_o}, 64'd0);
    check_eq("reset_result", result_o, 64'd0);
    rst = 1'b0;
    tick();

    run_div("u100_7",   1'b0, 32'd100,       32'd7,        64'h00000002_0000000E, 33);
    run_div("s-7_2",    1'b1, 32'hFFFFFFF9,  32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33);
    run_div("s7_-2",    1'b1, 32'h00000007,  32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    run_div("divzero",  1'b1, 32'hDEADBEEF,  32'h00000000, 64'h00000000_00000000, 2);
    run_div("smin_-1",  1'b1, 32'h80000000,  32'hFFFFFFFF, 64'h00000000_80000000, 33);
    run_div("umax_1",   1'b0, 32'hFFFFFFFF,  32'h00000001, 64'h00000000_FFFFFFFF, 33);

    // A request presented with annul high is not accepted.
    signed_div_i = 1'b0;
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    start_i = 1'b1;
    annul_i = 1'b1;
    tick();
    tick();
    check_eq("free_annul_ready", {63'd0, ready_o}, 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();

    // Annul during the 10th ON cycle, then issue 9/3 on the very next edge.
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      check_eq("annul_ready_low", {63'd0, ready_o}, 64'd0);
    end
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    check_eq("annul_ready", {63'd0, ready_o}, 64'd0);
    run_div("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // Reset at step 20, then a normal request.
    opdata1_i = 32'd77;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_ready", {63'd0, ready_o}, 64'd0);
    check_eq("midrst_result", result_o, 64'd0);
    run_div("after_rst", 1'b0, 32'd77, 32'd7, 64'h00000000_0000000B, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
